// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package reset_seq_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN,
    SWRST
  } seq_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync2 (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release after clock lock, with software-requested re-reset.
//
// state   | meaning
// HOLD    | all domains held; counting lock_s-high cycles up to DELAY_INIT
// RELEASE | releasing domains one by one, GAP cycles apart
// RUN     | every domain released, READY high, SW_REQ honoured
// SWRST   | all domains held for HOLD_SW cycles after a software request
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int               N_DOMAINS  = 3,
  parameter logic [CNT_W-1:0] DELAY_INIT = 16'hFFFF,
  parameter logic [CNT_W-1:0] GAP        = 16'h0100,
  parameter logic [CNT_W-1:0] HOLD_SW    = 16'h0040
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 LOCK,
  input  logic                 SW_REQ,
  output logic                 SW_ACK,
  output logic [N_DOMAINS-1:0] DOM_RST,
  output logic                 READY
);

  localparam int ST_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
  localparam logic [ST_W-1:0] LAST = ST_W'(N_DOMAINS - 1);

  logic                 lock_s;
  seq_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ST_W-1:0]      stage_q, stage_d, stage_nx;
  logic [N_DOMAINS-1:0] dom_q, dom_d;
  logic                 ready_q, ready_d;
  logic                 ack_q, ack_d;
  logic                 start_rel;

  sync2 u_lock_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (LOCK),
    .q   (lock_s)
  );

  assign stage_nx = stage_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    dom_d     = dom_q;
    ready_d   = ready_q;
    ack_d     = 1'b0;
    start_rel = 1'b0;

    // Losing lock wins over everything, including a pending SW_REQ.
    if (!lock_s) begin
      state_d = HOLD;
      cnt_d   = '0;
      stage_d = '0;
      dom_d   = '1;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == DELAY_INIT - 1'b1) start_rel = 1'b1;
          else                            cnt_d = cnt_q + 1'b1;
        end
        RELEASE: begin
          if (cnt_q == GAP - 1'b1) begin
            cnt_d           = '0;
            stage_d         = stage_nx;
            dom_d[stage_nx] = 1'b0;
            if (stage_nx == LAST) begin
              state_d = RUN;
              ready_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (SW_REQ) begin
            ack_d   = 1'b1;
            state_d = SWRST;
            cnt_d   = '0;
            dom_d   = '1;
            ready_d = 1'b0;
          end
        end
        SWRST: begin
          if (cnt_q == HOLD_SW - 1'b1) start_rel = 1'b1;
          else                         cnt_d = cnt_q + 1'b1;
        end
        default: state_d = HOLD;
      endcase

      // First domain release is shared by power-up and software reset paths.
      if (start_rel) begin
        cnt_d    = '0;
        stage_d  = '0;
        dom_d    = '1;
        dom_d[0] = 1'b0;
        if (N_DOMAINS == 1) begin
          state_d = RUN;
          ready_d = 1'b1;
        end else begin
          state_d = RELEASE;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      stage_q <= '0;
      dom_q   <= '1;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      dom_q   <= dom_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
    end
  end

  assign DOM_RST = dom_q;
  assign READY   = ready_q;
  assign SW_ACK  = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with short delays (8/4/5, three domains).
module tb_reset_sequencer;

  logic       CLK;
  logic       RST;
  logic       LOCK;
  logic       SW_REQ;
  logic       SW_ACK;
  logic [2:0] DOM_RST;
  logic       READY;

  int n_chk = 0;
  int n_err = 0;
  int ack_cnt = 0;
  int n;

  reset_sequencer #(
    .N_DOMAINS  (3),
    .DELAY_INIT (16'd8),
    .GAP        (16'd4),
    .HOLD_SW    (16'd5)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .LOCK    (LOCK),
    .SW_REQ  (SW_REQ),
    .SW_ACK  (SW_ACK),
    .DOM_RST (DOM_RST),
    .READY   (READY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (SW_ACK) ack_cnt++;
  endtask

  // Counts edges until DOM_RST reaches target; returns limit on timeout.
  task automatic wait_dom(input logic [2:0] target, input int limit, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (DOM_RST !== target && cnt < limit);
  endtask

  task automatic full_release(input string tag, input int first);
    wait_dom(3'b110, 40, n); check({tag, "_d0"}, n, first);
    check({tag, "_rdy_lo"}, READY, 0);
    wait_dom(3'b100, 40, n); check({tag, "_d1"}, n, 4);
    wait_dom(3'b000, 40, n); check({tag, "_d2"}, n, 4);
    check({tag, "_rdy"}, READY, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; LOCK = 1'b1; SW_REQ = 1'b0;
    repeat (3) step();
    check("rst_dom", DOM_RST, 3'b111);
    check("rst_rdy", READY, 0);
    check("rst_ack", SW_ACK, 0);

    // Power-up: 2 sync edges + 8 count edges to first release.
    RST = 1'b0;
    full_release("por", 10);

    // Single software request pulse.
    SW_REQ = 1'b1; step();
    check("sw_ack", SW_ACK, 1);
    check("sw_dom", DOM_RST, 3'b111);
    check("sw_rdy", READY, 0);
    SW_REQ = 1'b0; ack_cnt = 0;
    full_release("sw", 5);
    check("sw_single_ack", ack_cnt, 0);

    // Request held: one ack, then a second right after reaching RUN.
    SW_REQ = 1'b1; step();
    check("held_ack1", SW_ACK, 1);
    ack_cnt = 0;
    wait_dom(3'b000, 40, n); check("held_run", n, 13);
    check("held_no_extra", ack_cnt, 0);
    step();
    check("held_ack2", SW_ACK, 1);
    check("held_dom", DOM_RST, 3'b111);
    SW_REQ = 1'b0;
    wait_dom(3'b000, 40, n); check("held_run2", n, 13);

    // Lock loss reaching the FSM in RUN overrides a same-cycle SW_REQ.
    LOCK = 1'b0; step(); step();
    SW_REQ = 1'b1; ack_cnt = 0; step();
    check("ovr_ack", ack_cnt, 0);
    check("ovr_dom", DOM_RST, 3'b111);
    check("ovr_rdy", READY, 0);
    SW_REQ = 1'b0;

    // Glitch in HOLD after count reaches 5: counter must restart.
    LOCK = 1'b1;
    repeat (7) step();
    LOCK = 1'b0;
    repeat (3) step();
    check("glitch_hold", DOM_RST, 3'b111);
    LOCK = 1'b1;
    wait_dom(3'b110, 40, n); check("glitch_d0", n, 10);

    // Lock drop while stage=1.
    wait_dom(3'b100, 40, n); check("drop_d1", n, 4);
    LOCK = 1'b0; ack_cnt = 0;
    wait_dom(3'b111, 10, n); check("drop_lat", n, 3);
    check("drop_rdy", READY, 0);
    check("drop_ack", ack_cnt, 0);
    LOCK = 1'b1;

    // Asynchronous reset mid-release, SW_REQ ignored during restart.
    wait_dom(3'b110, 40, n); check("arst_d0", n, 10);
    #2 RST = 1'b1;
    #1;
    check("arst_dom", DOM_RST, 3'b111);
    check("arst_rdy", READY, 0);
    check("arst_ack", SW_ACK, 0);
    step(); step();
    RST = 1'b0; SW_REQ = 1'b1; ack_cnt = 0;
    wait_dom(3'b110, 40, n); check("arst_restart", n, 10);
    check("hold_rel_ignore", ack_cnt, 0);
    SW_REQ = 1'b0;
    wait_dom(3'b000, 40, n); check("arst_run", n, 8);
    check("arst_rdy_end", READY, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter N_DOMAINS, default 3: number of reset domains; bit 0 is released first.
REQ-002 SHALL have parameter DELAY_INIT, default 16'hFFFF: lock-to-first-release cycles, range 1..65535.
REQ-003 SHALL have parameter GAP, default 16'h0100: cycles between consecutive domain releases, range 1..65535.
REQ-004 SHALL have parameter HOLD_SW, default 16'h0040: cycles all domains are held during a software reset, range 1..65535.
REQ-005 SHALL have port CLK  in  1  sole clock; all logic on posedge.
REQ-006 SHALL have port RST  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port LOCK  in  1  PLL/clock-good, asynchronous to CLK.
REQ-008 SHALL have port SW_REQ  in  1  software reset request, level, synchronous to CLK.
REQ-009 SHALL have port SW_ACK  out  1  one-cycle acknowledge of SW_REQ.
REQ-010 SHALL have port DOM_RST  out  N_DOMAINS  per-domain active-high reset, registered.
REQ-011 SHALL have port READY  out  1  high only when every domain is released.

Function
REQ-012 SHALL synchronise LOCK through two flops to lock_s; all LOCK decisions use lock_s only.
REQ-013 SHALL implement states HOLD, RELEASE, RUN, SWRST.
REQ-014 In HOLD: all DOM_RST=1, READY=0; 16-bit counter increments each cycle lock_s=1 and clears to 0 each cycle lock_s=0.
REQ-015 HOLD->RELEASE on the edge where counter==DELAY_INIT-1 and lock_s=1; on that edge DOM_RST[0] SHALL go 0, stage=0, counter=0.
REQ-016 In RELEASE: counter increments each cycle; when counter==GAP-1, stage increments, DOM_RST[stage+1] goes 0 on that edge, counter=0.
REQ-017 Released domains SHALL stay released; unreleased domains stay asserted (monotone release order 0..N-1).
REQ-018 RELEASE->RUN on the edge releasing DOM_RST[N_DOMAINS-1]; READY SHALL go 1 on that same edge.
REQ-019 N_DOMAINS=1: HOLD->RUN directly; DOM_RST[0] falls and READY rises on the same edge.
REQ-020 In RUN with SW_REQ=1: SW_ACK=1 for exactly one cycle, and on that same edge all DOM_RST=1, READY=0, counter=0, state SWRST.
REQ-021 SW_REQ SHALL be ignored (SW_ACK stays 0) in HOLD, RELEASE, SWRST; SW_REQ held high re-triggers only after returning to RUN.
REQ-022 SWRST: all DOM_RST=1; when counter==HOLD_SW-1, enter RELEASE with DOM_RST[0]=0, stage=0 (DELAY_INIT skipped).
REQ-023 lock_s=0 in any state SHALL, on the next edge, assert all DOM_RST, clear READY, counter and stage, enter HOLD; this overrides SW_REQ on the same cycle.
REQ-024 Counter and stage SHALL never wrap: comparisons stop counting at the transition.

Reset
REQ-025 RST=1 SHALL asynchronously force: state HOLD, DOM_RST all 1, READY 0, SW_ACK 0, counter 0, stage 0, synchroniser flops 0.
REQ-026 RST mid-RELEASE or mid-SWRST SHALL abandon the sequence; restart begins with full DELAY_INIT after RST falls.

Structure
REQ-027 Package reset_seq_pkg SHALL hold the state enum and CNT_W=16 constant.
REQ-028 Sub-module sync2 (two-flop synchroniser, async active-high reset to 0) SHALL be used for LOCK.

Verification (DELAY_INIT=8, GAP=4, HOLD_SW=5, N_DOMAINS=3)
REQ-029 Power-up: RST 1->0, LOCK=1 -> DOM_RST[0] falls 8 cycles after lock_s rises, [1] 4 cycles later, [2] and READY 4 cycles after that.
REQ-030 LOCK glitch low 3 cycles during HOLD count=5 -> counter clears; full 8 cycles counted after lock_s returns.
REQ-031 SW_REQ pulse in RUN -> SW_ACK one cycle, DOM_RST=3'b111 same edge; DOM_RST[0] falls 5 cycles later, [1] +4, [2] and READY +4.
REQ-032 SW_REQ held high through SWRST/RELEASE -> single SW_ACK; second SW_ACK on first RUN cycle.
REQ-033 LOCK drop while stage=1 in RELEASE -> DOM_RST=3'b111, READY=0 two-to-three cycles later; no SW_ACK.
REQ-034 RST asserted mid-RELEASE asynchronously (between edges) -> outputs reset immediately; sequence restarts from HOLD.
